// File: rtl/seq_detector_p.sv
// Programmable symbol-sequence detector. Compares the newest SEQ_LEN accepted
// symbols against a runtime-loaded pattern and pulses `match` one cycle after
// the completing symbol. Supports overlapping and non-overlapping detection
// and keeps a saturating match counter.
module seq_detector_p #(
    parameter int unsigned SYM_W   = 2,
    parameter int unsigned SEQ_LEN = 3,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_load,
    input  logic [SEQ_LEN*SYM_W-1:0]     cfg_pattern,
    input  logic                         cfg_overlap,
    input  logic                         in_valid,
    input  logic [SYM_W-1:0]             in_sym,
    input  logic                         cnt_clr,
    output logic                         match,
    output logic [CNT_W-1:0]             match_count,
    output logic [$clog2(SEQ_LEN+1)-1:0] fill
);

    localparam int unsigned PAT_W  = SEQ_LEN * SYM_W;
    localparam int unsigned FILL_W = $clog2(SEQ_LEN + 1);

    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(SEQ_LEN);
    // One symbol short of a full window: the incoming symbol completes it.
    localparam logic [FILL_W-1:0] FILL_ARM = FILL_W'(SEQ_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic [PAT_W-1:0]  pattern_q, pattern_d;
    logic              overlap_q, overlap_d;
    logic [PAT_W-1:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              match_q, match_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              accept;
    logic              hit;
    logic [PAT_W-1:0]  window;

    // Candidate window: history positions 1..SEQ_LEN-1 with the new symbol on top.
    assign window = {in_sym, hist_q[PAT_W-1:SYM_W]};
    assign accept = in_valid & ~cfg_load;
    assign hit    = accept & (fill_q >= FILL_ARM) & (window == pattern_q);

    // State register; synchronous reset overrides every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            pattern_q <= '0;
            overlap_q <= 1'b1;
            hist_q    <= '0;
            fill_q    <= '0;
            match_q   <= 1'b0;
            count_q   <= '0;
        end else begin
            pattern_q <= pattern_d;
            overlap_q <= overlap_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            count_q   <= count_d;
        end
    end

    // Next-state: configuration load wins over an accept in the same cycle.
    always_comb begin
        pattern_d = pattern_q;
        overlap_d = overlap_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        match_d   = 1'b0;

        if (cfg_load) begin
            pattern_d = cfg_pattern;
            overlap_d = cfg_overlap;
            fill_d    = '0;
        end else if (in_valid) begin
            hist_d  = window;
            match_d = hit;
            if (hit && !overlap_q) begin
                // Non-overlapping: demand SEQ_LEN fresh symbols before the next match.
                fill_d = '0;
            end else if (fill_q != FILL_MAX) begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    // Match counter: clear beats a coincident match, saturates without wrap.
    always_comb begin
        count_d = count_q;
        if (cnt_clr) begin
            count_d = '0;
        end else if (hit && (count_q != CNT_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    assign match       = match_q;
    assign match_count = count_q;
    assign fill        = fill_q;

endmodule

// File: tb/tb_seq_detector_p.sv
// Scoreboard bench for seq_detector_p: the driver updates a queue-based
// reference model on every cycle and pushes the expected outputs; a monitor
// pops one entry per clock and compares it with the DUT.
module tb_seq_detector_p;

    localparam int unsigned SYM_W   = 2;
    localparam int unsigned SEQ_LEN = 3;
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned PW      = SEQ_LEN * SYM_W;
    localparam int unsigned FW      = $clog2(SEQ_LEN + 1);
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    localparam logic [PW-1:0] P_LEG = 6'b11_10_01;
    localparam logic [PW-1:0] P_01  = 6'b01_01_01;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_load;
    logic [PW-1:0]    cfg_pattern;
    logic             cfg_overlap;
    logic             in_valid;
    logic [SYM_W-1:0] in_sym;
    logic             cnt_clr;
    logic             match;
    logic [CNT_W-1:0] match_count;
    logic [FW-1:0]    fill;

    seq_detector_p #(
        .SYM_W   (SYM_W),
        .SEQ_LEN (SEQ_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_overlap (cfg_overlap),
        .in_valid    (in_valid),
        .in_sym      (in_sym),
        .cnt_clr     (cnt_clr),
        .match       (match),
        .match_count (match_count),
        .fill        (fill)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic m;
        int   c;
        int   f;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: the window is simply the list of fresh symbols.
    logic [SYM_W-1:0] m_pat[SEQ_LEN];
    logic             m_ovl;
    logic [SYM_W-1:0] m_win[$];
    int               m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model(input bit r, input bit ld, input logic [PW-1:0] pat, input bit ov,
                         input bit v, input logic [SYM_W-1:0] s, input bit cl);
        exp_t e;
        bit   hit;
        hit = 1'b0;
        if (r) begin
            m_win.delete();
            m_cnt = 0;
            for (int k = 0; k < SEQ_LEN; k++) m_pat[k] = '0;
            m_ovl = 1'b1;
        end else begin
            if (ld) begin
                for (int k = 0; k < SEQ_LEN; k++) m_pat[k] = pat[k*SYM_W +: SYM_W];
                m_ovl = ov;
                m_win.delete();
            end else if (v) begin
                m_win.push_back(s);
                if (m_win.size() > SEQ_LEN) void'(m_win.pop_front());
                if (m_win.size() == SEQ_LEN) begin
                    hit = 1'b1;
                    for (int k = 0; k < SEQ_LEN; k++) if (m_win[k] != m_pat[k]) hit = 1'b0;
                end
                if (hit && !m_ovl) m_win.delete();
            end
            if (cl) m_cnt = 0;
            else if (hit && m_cnt < CNT_MAX) m_cnt++;
        end
        e.m = hit;
        e.c = m_cnt;
        e.f = m_win.size();
        sb.push_back(e);
    endtask

    task automatic drive(input bit r, input bit ld, input logic [PW-1:0] pat, input bit ov,
                         input bit v, input int s, input bit cl);
        @(negedge clk);
        rst         = r;
        cfg_load    = ld;
        cfg_pattern = pat;
        cfg_overlap = ov;
        in_valid    = v;
        in_sym      = SYM_W'(s);
        cnt_clr     = cl;
        model(r, ld, pat, ov, v, SYM_W'(s), cl);
    endtask

    task automatic sym(input int s);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b1, s, 1'b0);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic load(input logic [PW-1:0] pat, input bit ov);
        drive(1'b0, 1'b1, pat, ov, 1'b0, 0, 1'b0);
    endtask

    task automatic clr();
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 0, 1'b1);
    endtask

    // Monitor: outputs settle after each edge; compare against the oldest expectation.
    exp_t mon_e;
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("match", 32'(match), 32'(mon_e.m));
            chk("count", 32'(match_count), mon_e.c);
            chk("fill", 32'(fill), mon_e.f);
        end
    end

    // Directed checks read outputs right after an idle() call, i.e. the
    // response to the step issued just before it.
    initial begin
        logic [PW-1:0] rp;
        bit            narrow;
        rst = 1'b1; cfg_load = 1'b0; cfg_pattern = '0; cfg_overlap = 1'b0;
        in_valid = 1'b0; in_sym = '0; cnt_clr = 1'b0;

        drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 0, 1'b0);
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 0, 1'b0);
        idle();
        chk("rst_match", 32'(match), 0);
        chk("rst_count", 32'(match_count), 0);
        chk("rst_fill", 32'(fill), 0);

        // Legacy pattern
        load(P_LEG, 1'b1);
        sym(1); sym(2); sym(3);
        idle();
        chk("s1_match", 32'(match), 1);
        chk("s1_count", 32'(match_count), 1);
        chk("s1_fill", 32'(fill), 3);
        idle();
        chk("s1_pulse_end", 32'(match), 0);

        // Overlapping
        clr();
        load(P_01, 1'b1);
        repeat (5) sym(1);
        idle();
        chk("s2_count", 32'(match_count), 3);

        // Non-overlapping
        clr();
        load(P_01, 1'b0);
        repeat (5) sym(1);
        idle();
        chk("s3_count", 32'(match_count), 1);
        chk("s3_fill", 32'(fill), 2);
        sym(1);
        idle();
        chk("s3_match6", 32'(match), 1);
        chk("s3_count6", 32'(match_count), 2);

        // Gaps do not break a partial sequence
        clr();
        load(P_LEG, 1'b1);
        sym(1); repeat (4) idle(); sym(2); idle(); sym(3);
        idle();
        chk("s4_match", 32'(match), 1);
        chk("s4_count", 32'(match_count), 1);
        sym(1); sym(2); sym(0);
        idle();
        chk("s4_nomatch", 32'(match), 0);
        chk("s4_fill", 32'(fill), 3);

        // cfg_load discards the coincident symbol and clears the window
        load(P_LEG, 1'b1);
        sym(1); sym(2);
        drive(1'b0, 1'b1, P_LEG, 1'b1, 1'b1, 3, 1'b0);
        idle();
        chk("s5_match", 32'(match), 0);
        chk("s5_fill", 32'(fill), 0);
        sym(1); sym(2); sym(3);
        idle();
        chk("s5_rematch", 32'(match), 1);

        // Saturation, reset priority, clear beats match
        clr();
        load(P_01, 1'b1);
        repeat (8) sym(1);
        idle();
        chk("s6_sat", 32'(match_count), 3);
        drive(1'b1, 1'b0, '0, 1'b0, 1'b1, 1, 1'b1);
        idle();
        chk("s6_rst_match", 32'(match), 0);
        chk("s6_rst_count", 32'(match_count), 0);
        chk("s6_rst_fill", 32'(fill), 0);
        load(P_01, 1'b1);
        sym(1); sym(1);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b1, 1, 1'b1);
        idle();
        chk("s6_clr_match", 32'(match), 1);
        chk("s6_clr_count", 32'(match_count), 0);

        // Randomised traffic against the model
        narrow = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            bit r, ld, v, cl;
            int s;
            r  = ($urandom_range(0, 199) == 0);
            ld = ($urandom_range(0, 59) == 0);
            v  = ($urandom_range(0, 9) < 7);
            cl = ($urandom_range(0, 39) == 0);
            for (int k = 0; k < SEQ_LEN; k++) rp[k*SYM_W +: SYM_W] = SYM_W'($urandom_range(1, 2));
            if (ld) narrow = ($urandom_range(0, 3) != 0);
            s = narrow ? $urandom_range(1, 2) : $urandom_range(0, 3);
            drive(r, ld, rp, 1'($urandom_range(0, 1)), v, s, cl);
        end

        idle();
        @(posedge clk);
        #2;
        chk("sb_drain", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
